// File: rtl/pipe_buffer.sv
// pipe_buffer: elastic valid/allow_in pipeline register with flush and DEPTH-entry circular storage
module pipe_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             allow_in,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_allow_in,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic push, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign out_valid = count != '0;
  // Multi-entry buffers decide allow_in from registered state only, cutting the ready chain.
  assign allow_in = DEPTH == 1 ? (~out_valid | out_allow_in) : (count != CNT_W'(DEPTH));
  assign push = in_valid & allow_in & ~flush;
  assign pop = out_valid & out_allow_in;
  assign out_data = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr <= inc(wr_ptr);
      end
      if (pop) rd_ptr <= inc(rd_ptr);
      if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
    end
  end
endmodule

// File: doc/pipe_buffer.md
# pipe_buffer

Parametrised elastic pipeline register for the valid/allow_in handshake used between CPU pipeline stages such as IF→ID, ID→EX, EX→MEM and MEM→WB. It latches the stage payload and holds it stably under downstream stall. It adds a synchronous flush for branch redirect and optional multi-entry buffering. With DEPTH ≥ 2, its upstream allow_in no longer depends combinationally on downstream allow_in, which breaks the long ready chain across all stages.

## Interface
Parameters:
- WIDTH, 64, payload bits per entry (for example {pc, inst} = 64).
- DEPTH, 2, number of entries; legal values are 1 to 8, and non-powers of two are allowed.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discards all held entries and any push in the same cycle.
- in_valid  in  1  upstream offers in_data this cycle.
- allow_in  out  1  buffer accepts a push this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry is valid.
- out_allow_in  in  1  downstream allow_in.
- out_data  out  WIDTH  head entry payload.
- count  out  CNT_W  number of valid entries held.

## Operation
- push = in_valid & allow_in & ~flush.
- pop = out_valid & out_allow_in.
- Storage is a circular array of DEPTH entries, with head pointer rd_ptr and tail pointer wr_ptr.
- Each pointer increments by 1 and wraps explicitly from DEPTH-1 to 0, so a non-power-of-two DEPTH is legal.
- On push, in_data is written at wr_ptr and wr_ptr advances.
- On pop, rd_ptr advances.
- count updates as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when push and pop occur together.
- out_valid = (count != 0).
- out_data = entry[rd_ptr], driven directly from storage.
- allow_in rule:
  - DEPTH = 1: allow_in = ~out_valid | out_allow_in. This matches single-register stage behaviour; on a full-buffer push with simultaneous pop, the entry is replaced.
  - DEPTH ≥ 2: allow_in = (count != DEPTH). It is a function of registered state only and has no combinational path from out_allow_in.
- flush:
  - Next cycle, count = 0 and rd_ptr = wr_ptr = 0.
  - It overrides push and pop. The pop handshake in the flush cycle still completes downstream, because downstream already saw out_valid.
  - allow_in is not gated by flush; the push is simply dropped.
- Data in storage is never modified except at wr_ptr on push.
- Data at the head stays stable while out_valid & ~out_allow_in.
- Overflow: there is no push when allow_in = 0, by construction.
- Underflow: there is no pop when out_valid = 0, by construction.

## Timing
- Reset (synchronous, one cycle), the value of every output in the cycle after reset is sampled:
  - count = 0, out_valid = 0, rd_ptr = wr_ptr = 0.
  - All storage entries are cleared to 0, so out_data = 0.
  - allow_in = 1.
- Reset has priority over flush, push and pop. Reset asserted mid-stream drops all entries.
- Latency: there is no fall-through. Data pushed at edge N appears on out_data/out_valid after edge N, i.e. in cycle N+1.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- With DEPTH = 1, this also holds at count = 1 when out_allow_in = 1.
- With DEPTH = 2, a full buffer with continuous pop accepts again in the cycle after the pop edge, because allow_in is registered-state based. Steady-state full throughput needs a downstream that keeps count below DEPTH.
- count, out_valid and allow_in (for DEPTH ≥ 2) change only on rising clk edges.

## Test plan
- **Reset values:** apply reset for 2 cycles with in_valid=1 and in_data=64'hDEAD → after reset, count=0, out_valid=0, out_data=0, allow_in=1, and nothing is pushed.
- **Stream with stall (DEPTH=2):**
  - Stimulus: push A=64'h1C000000_00000001, B=…02 and C=…03 on consecutive cycles with out_allow_in=0.
  - Required: A and B are accepted, count=2, allow_in=0, and C is held upstream.
  - Then raise out_allow_in: outputs appear in order A, B, C; out_data=A is stable for the whole stall; there is no loss or duplication.
- **Simultaneous push/pop:** with count=1, push D while popping the head each cycle for 10 cycles → count stays 1, and the output order equals the input order.
- **Flush:**
  - Stimulus: with count=2, assert flush together with in_valid=1 and in_data=E.
  - Required: next cycle count=0 and out_valid=0; E never appears.
  - Then push F → F appears at out_data one cycle later.
- **Wrap-around (DEPTH=3):** push and pop 7 entries with a random out_allow_in pattern → the pointers wrap 2→0 correctly and the output sequence matches the input sequence.
- **DEPTH=1 compatibility:** with full buffer and out_allow_in=1, in_valid=1 → allow_in=1 in the same cycle; the entry is replaced with no bubble. With out_allow_in=0 → allow_in=0.
